fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter HALT_INSTR, default 32'hFFFF_FFFF, instruction word that stops fetching.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  leave IDLE and begin fetching.
REQ-006 stall  input  1  consumer not accepting; holds the delivered instruction.
REQ-007 jump / jump_target  input  1 / 32  unconditional redirect and its target.
REQ-008 branch_taken / branch_target  input  1 / 32  conditional redirect and its target.
REQ-009 imem_req / imem_addr  output  1 / 32  instruction-memory request and word address.
REQ-010 imem_ack / imem_rdata  input  1 / 32  memory completion and returned word.
REQ-011 instr_valid / instr / instr_pc  output  1 / 32 / 32  delivered instruction and its address.
REQ-012 pc  output  32  current fetch PC.
REQ-013 halted  output  1  HALT_INSTR fetched; fetching stopped.

Function
REQ-014 States: IDLE, FETCH, DELIVER, HALTED; all outputs registered.
REQ-015 IDLE: imem_req=0; start=1 -> FETCH next cycle.
REQ-016 FETCH: imem_req=1, imem_addr=pc, both stable until imem_ack.
REQ-017 Latency: start sampled at edge N -> imem_req=1 from cycle N+1.
REQ-018 FETCH + imem_ack: imem_req=0 next cycle; imem_rdata != HALT_INSTR -> instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, go DELIVER.
REQ-019 FETCH + imem_ack with imem_rdata == HALT_INSTR -> HALTED, halted<=1, instr_valid stays 0.
REQ-020 DELIVER: instr_valid=1; instr and instr_pc held constant while stall=1.
REQ-021 DELIVER with stall=0 is the accept cycle: instr_valid<=0, pc<=next PC, go FETCH.
REQ-022 Next PC: jump ? jump_target : branch_taken ? branch_target : pc+4; jump has priority when both asserted.
REQ-023 Redirect targets have bits [1:0] forced to 0; pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 jump/branch_taken are sampled only in the accept cycle and ignored at all other times.
REQ-025 imem_ack is ignored outside FETCH; start is ignored outside IDLE.
REQ-026 HALTED: imem_req=0, halted=1; state is left only via rst.
REQ-027 Throughput: at most one instruction per two cycles (FETCH with immediate ack, then DELIVER).

Reset
REQ-028 rst=1 at an edge -> state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, halted=0.
REQ-029 rst has priority over all other inputs in every state, including mid-FETCH; an imem_ack arriving in or after the reset cycle is discarded.

Structure
REQ-030 Package fetch_pkg holds the state enum, PC_INC=4, and the RESET_PC and HALT_INSTR defaults.
REQ-031 The combinational next-PC mux with target alignment is the sub-module next_pc_sel; everything else is in fetch_ctrl.

Verification
REQ-032 rst, start=1, imem_ack on 2nd FETCH cycle, rdata=32'h2001_0005, stall=0 -> imem_addr=0, instr_valid with instr_pc=0, then imem_addr=4.
REQ-033 DELIVER with stall=1 for 3 cycles -> instr and instr_pc unchanged; imem_req=0 throughout; FETCH of pc+4 one cycle after stall falls.
REQ-034 Accept cycle with jump=1, jump_target=32'h100, branch_taken=1, branch_target=32'h200 -> next imem_addr=32'h100; target 32'h203 alone -> 32'h200.
REQ-035 pc=32'hFFFF_FFFC, accept without redirect -> next imem_addr=32'h0000_0000.
REQ-036 rdata=32'hFFFF_FFFF -> halted=1, instr_valid=0, imem_req stays 0 despite start/ack; rst -> IDLE, halted=0.
REQ-037 rst asserted while in FETCH with imem_req=1, ack in same cycle -> imem_req=0, instr_valid=0, pc=RESET_PC next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FETCH   = 2'd1,
      S_DELIVER = 2'd2,
      S_HALTED  = 2'd3
   } fetch_state_t;

   localparam logic [31:0] PC_INC         = 32'd4;
   localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] DEF_HALT_INSTR = 32'hFFFF_FFFF;

endpackage

// File: rtl/next_pc_sel.sv
// Next fetch address selection: jump beats branch beats sequential.
// Redirect targets are word aligned; the sequential add wraps naturally.
module next_pc_sel
   import fetch_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic        jump_i,
   input  logic [31:0] jump_target_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   output logic [31:0] next_pc_o
);

   // Priority mux over the three possible successors.
   always_comb begin
      next_pc_o = pc_i + PC_INC;
      if (jump_i)
         next_pc_o = {jump_target_i[31:2], 2'b00};
      else if (branch_taken_i)
         next_pc_o = {branch_target_i[31:2], 2'b00};
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: requests one word at a time from instruction
// memory, hands it to the consumer, then advances or redirects the PC.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
   parameter logic [31:0] HALT_INSTR = DEF_HALT_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stall,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] pc,
   output logic        halted
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         req_q, req_d;
   logic         valid_q, valid_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  ipc_q, ipc_d;
   logic         halted_q, halted_d;
   logic [31:0]  next_pc;

   next_pc_sel u_next_pc_sel (
      .pc_i            (pc_q),
      .jump_i          (jump),
      .jump_target_i   (jump_target),
      .branch_taken_i  (branch_taken),
      .branch_target_i (branch_target),
      .next_pc_o       (next_pc)
   );

   // Next-state and registered-output decisions; everything holds by default.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_d    = req_q;
      valid_d  = valid_q;
      instr_d  = instr_q;
      ipc_d    = ipc_q;
      halted_d = halted_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;
               req_d   = 1'b1;
            end
         end
         S_FETCH: begin
            if (imem_ack) begin
               req_d = 1'b0;
               if (imem_rdata == HALT_INSTR) begin
                  state_d  = S_HALTED;
                  halted_d = 1'b1;
               end else begin
                  state_d = S_DELIVER;
                  valid_d = 1'b1;
                  instr_d = imem_rdata;
                  ipc_d   = pc_q;
               end
            end
         end
         S_DELIVER: begin
            // Redirect inputs only matter in the cycle the consumer accepts.
            if (!stall) begin
               state_d = S_FETCH;
               valid_d = 1'b0;
               pc_d    = next_pc;
               req_d   = 1'b1;
            end
         end
         S_HALTED: begin
            state_d = S_HALTED;
         end
         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
            valid_d = 1'b0;
         end
      endcase
   end

   // State register; reset wins over any in-flight acknowledge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         req_q    <= 1'b0;
         valid_q  <= 1'b0;
         instr_q  <= 32'h0;
         ipc_q    <= 32'h0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_q    <= req_d;
         valid_q  <= valid_d;
         instr_q  <= instr_d;
         ipc_q    <= ipc_d;
         halted_q <= halted_d;
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr_valid = valid_q;
   assign instr       = instr_q;
   assign instr_pc    = ipc_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations, then
// random traffic compared every cycle against a behavioural model.
module tb_fetch_ctrl;

   localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b0, start = 1'b0, stall = 1'b0;
   logic        jump = 1'b0, branch_taken = 1'b0;
   logic [31:0] jump_target = '0, branch_target = '0;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        imem_req, instr_valid, halted;
   logic [31:0] imem_addr, instr, instr_pc, pc;

   int checks = 0;
   int errors = 0;

   fetch_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .stall(stall),
      .jump(jump), .jump_target(jump_target),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .pc(pc), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: what the consumer and memory should observe.
   // mode: 0 waiting for start, 1 requesting, 2 offering a word, 3 stopped
   int          m_mode = 0;
   bit          armed = 0;
   logic        m_req = 0, m_valid = 0, m_halted = 0;
   logic [31:0] m_pc = 0, m_instr = 0, m_ipc = 0;

   task automatic model_step();
      if (rst) begin
         armed = 1; m_mode = 0; m_pc = 32'h0; m_req = 0;
         m_valid = 0; m_instr = 0; m_ipc = 0; m_halted = 0;
      end else if (m_mode == 0) begin
         if (start) begin m_mode = 1; m_req = 1; end
      end else if (m_mode == 1) begin
         if (imem_ack) begin
            m_req = 0;
            if (imem_rdata == HALTW) begin m_mode = 3; m_halted = 1; end
            else begin m_mode = 2; m_valid = 1; m_instr = imem_rdata; m_ipc = m_pc; end
         end
      end else if (m_mode == 2) begin
         if (!stall) begin
            if (jump)              m_pc = jump_target & ~32'd3;
            else if (branch_taken) m_pc = branch_target & ~32'd3;
            else                   m_pc = m_pc + 32'd4;
            m_valid = 0; m_req = 1; m_mode = 1;
         end
      end
   endtask

   // Per-cycle compare against the model, just after each edge.
   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         if (armed) begin
            chk("m_req",    {31'b0, imem_req},    {31'b0, m_req});
            chk("m_addr",   imem_addr,            m_pc);
            chk("m_pc",     pc,                   m_pc);
            chk("m_valid",  {31'b0, instr_valid}, {31'b0, m_valid});
            chk("m_instr",  instr,                m_instr);
            chk("m_ipc",    instr_pc,             m_ipc);
            chk("m_halted", {31'b0, halted},      {31'b0, m_halted});
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      // Reset state and first fetch with ack on the second FETCH cycle.
      tick(); rst = 1; tick(); rst = 0;
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_halted", {31'b0, halted}, 32'd0);
      start = 1; tick(); start = 0;
      chk("f1_req", {31'b0, imem_req}, 32'd1);
      chk("f1_addr", imem_addr, 32'h0);
      tick();
      chk("f1_req_hold", {31'b0, imem_req}, 32'd1);
      imem_ack = 1; imem_rdata = 32'h2001_0005; tick(); imem_ack = 0;
      chk("d1_valid", {31'b0, instr_valid}, 32'd1);
      chk("d1_instr", instr, 32'h2001_0005);
      chk("d1_ipc", instr_pc, 32'h0);
      chk("d1_req", {31'b0, imem_req}, 32'd0);
      tick();
      chk("f2_addr", imem_addr, 32'h4);
      chk("f2_req", {31'b0, imem_req}, 32'd1);

      // Stall holds the delivered word for three cycles.
      imem_ack = 1; imem_rdata = 32'h1234_5678; stall = 1; tick(); imem_ack = 0;
      for (int i = 0; i < 3; i++) begin
         chk("st_instr", instr, 32'h1234_5678);
         chk("st_ipc", instr_pc, 32'h4);
         chk("st_req", {31'b0, imem_req}, 32'd0);
         chk("st_valid", {31'b0, instr_valid}, 32'd1);
         tick();
      end
      stall = 0; tick();
      chk("st_next_addr", imem_addr, 32'h8);
      chk("st_next_req", {31'b0, imem_req}, 32'd1);

      // Jump beats branch; branch target is aligned.
      imem_ack = 1; imem_rdata = 32'h1; tick(); imem_ack = 0;
      jump = 1; jump_target = 32'h100; branch_taken = 1; branch_target = 32'h200;
      tick(); jump = 0; branch_taken = 0;
      chk("jmp_prio", imem_addr, 32'h100);
      imem_ack = 1; tick(); imem_ack = 0;
      branch_taken = 1; branch_target = 32'h203; tick(); branch_taken = 0;
      chk("br_align", imem_addr, 32'h200);

      // Sequential wrap at the top of the address space.
      imem_ack = 1; tick(); imem_ack = 0;
      jump = 1; jump_target = 32'hFFFF_FFFF; tick(); jump = 0;
      chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
      imem_ack = 1; tick(); imem_ack = 0;
      tick();
      chk("wrap_addr", imem_addr, 32'h0);

      // Reset mid-fetch with a simultaneous ack.
      chk("mid_req", {31'b0, imem_req}, 32'd1);
      rst = 1; imem_ack = 1; imem_rdata = 32'h5; tick(); rst = 0;
      chk("mr_req", {31'b0, imem_req}, 32'd0);
      chk("mr_valid", {31'b0, instr_valid}, 32'd0);
      chk("mr_pc", pc, 32'h0);
      tick(); imem_ack = 0;
      chk("mr_ack_ign", {31'b0, instr_valid}, 32'd0);

      // Halt word stops fetching until reset.
      start = 1; tick(); start = 0;
      imem_ack = 1; imem_rdata = HALTW; tick(); imem_ack = 0;
      chk("h_halted", {31'b0, halted}, 32'd1);
      chk("h_valid", {31'b0, instr_valid}, 32'd0);
      chk("h_req", {31'b0, imem_req}, 32'd0);
      start = 1; imem_ack = 1; imem_rdata = 32'h7; tick(); tick(); start = 0; imem_ack = 0;
      chk("h_stay", {31'b0, halted}, 32'd1);
      chk("h_req2", {31'b0, imem_req}, 32'd0);
      rst = 1; tick(); rst = 0;
      chk("h_rst", {31'b0, halted}, 32'd0);
      chk("h_rst_req", {31'b0, imem_req}, 32'd0);

      // Random traffic; the compare process checks every cycle.
      for (int c = 0; c < 4000; c++) begin
         rst           = ($urandom % 150) == 0;
         start         = ($urandom % 4) == 0;
         stall         = ($urandom % 3) == 0;
         jump          = ($urandom % 5) == 0;
         jump_target   = (($urandom % 8) == 0) ? 32'hFFFF_FFF8 + ($urandom % 8) : $urandom;
         branch_taken  = ($urandom % 4) == 0;
         branch_target = $urandom;
         imem_ack      = imem_req ? (($urandom % 2) == 0) : (($urandom % 6) == 0);
         imem_rdata    = (($urandom % 24) == 0) ? HALTW : $urandom;
         tick();
      end
      rst = 0; start = 0; imem_ack = 0;
      tick(); tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
